bcd_updown_counter: RTL and testbench
=====================================

// Module: bcd_updown_counter
// PURPOSE
//  - Parametrised N-digit decimal up/down counter that counts directly in BCD, so the
//    display path needs no separate hex-to-BCD converter.
//  - Runs on the single system clock. An internal prescaler generates the count rate,
//    replacing a divided clock.
//  - Adds load, clear, wrap/saturate mode and an overflow pulse.
//  - Digit outputs feed the TM1638 driver segment inputs directly.
// PARAMETERS
//  NUM_DIGITS  3         number of BCD digits (1..8); MAX = 10^NUM_DIGITS - 1
//  TICK_DIV    50000000  clk_50M cycles per auto-count tick (>=2)
//  WRAP        1         1: roll over at MAX/0; 0: saturate at MAX/0
// PORTS
//  clk_50M   in   1               system clock, all state on rising edge
//  rst       in   1               asynchronous reset, active-high
//  en        in   1               enables prescaler and auto-count; 0 freezes prescaler
//  up        in   1               direction: 1 count up, 0 count down
//  step      in   1               one-cycle manual step request (independent of en)
//  clr       in   1               synchronous clear to 0
//  load      in   1               synchronous load of load_val
//  load_val  in   4*NUM_DIGITS    BCD load value, digit 0 in [3:0]
//  digits    out  4*NUM_DIGITS    current count, BCD, digit 0 (ones) in [3:0]
//  tick      out  1               1-cycle pulse on each prescaler terminal count
//  ovf       out  1               1-cycle pulse on overflow/underflow event
//  zero      out  1               high while count == 0
// BEHAVIOUR
//  - Reset (async, any time): digits=0, prescaler=0, tick=0, ovf=0, zero=1.
//    Mid-operation reset discards any pending step.
//  - Prescaler: when en=1 it counts 0..TICK_DIV-1 and wraps. The cycle it equals
//    TICK_DIV-1 raises a step event and registers tick=1 for the next cycle.
//    When en=0 it holds its value and tick=0.
//    clr and load also reset the prescaler to 0.
//  - Step event = prescaler terminal OR step. Both in the same cycle produce ONE step.
//  - Priority per cycle: clr > load > step event. A lower-priority request in the same
//    cycle is dropped.
//  - Latency: digits/ovf/zero reflect a request in the cycle after it is sampled.
//  - Load: each digit of load_val greater than 9 is clamped to 9. No ovf on load.
//  - Up step: ripple BCD increment; digit 9 -> 0 with carry into the next digit.
//    At MAX: WRAP=1 -> 0; WRAP=0 -> hold MAX. ovf=1 in both modes.
//  - Down step: ripple decrement; digit 0 -> 9 with borrow.
//    At 0: WRAP=1 -> MAX; WRAP=0 -> hold 0. ovf=1 in both modes.
//  - up is sampled on the step cycle only; direction changes take effect immediately.
//  - ovf is low in every cycle without an overflow event. zero is decoded from the register.
//  - digits never holds a non-BCD nibble.
// STRUCTURE
//  - Shared package/header: BCD_MAX_DIGIT=4'd9 and a bcd_clamp function (nibble > 9 -> 9).
//  - Sub-module bcd_digit, instantiated NUM_DIGITS times via generate:
//    inputs inc, dec, load, load_d, clr, wrap_en; outputs d[3:0], carry, borrow.
//    Carry/borrow is combinational to the next digit.
//  - Top-level logic: prescaler, event merge, priority, MAX/0 detect, ovf/zero/tick
//    registers.
// TESTING  (NUM_DIGITS=3, TICK_DIV=4 unless noted)
//  - Reset/auto-count: release rst, en=1, up=1 -> tick every 4 cycles;
//    digits 000,001,002...; zero=1 only before the first step.
//  - Wrap up: load 12'h998, WRAP=1, 2 ticks -> 999 then 000, with ovf=1 for exactly
//    1 cycle on the 999->000 step. Down from 000 -> 999 with ovf pulse.
//  - Saturate: WRAP=0, load 999, up step -> stays 999, ovf pulses. load 000, down step
//    -> stays 000, ovf pulses.
//  - Priority/merge: same cycle clr=1, load=1, step=1 -> 000, prescaler 0.
//    load+step -> load value only. Manual step coinciding with a tick -> +1, not +2.
//  - Load clamp/carry: load_val=12'hA5F -> 959. Up step -> 960; load 099, up -> 100.
//  - Async reset mid-count: assert rst between clock edges at count 057 -> digits 000
//    immediately, before the next clk_50M edge; en=0 -> prescaler and digits frozen,
//    but step still counts.

Source files
------------

// File: rtl/bcd_updown_counter_pkg.sv
// Shared constants and helpers for the BCD up/down counter.
package bcd_updown_counter_pkg;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  // Any nibble above 9 is forced to 9 so a register never holds a non-BCD digit.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] nib);
    return (nib > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : nib;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the counter. Carry and borrow are combinational so the
// ripple through all digits settles within a single clock cycle.
module bcd_digit
  import bcd_updown_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [3:0] load_d,
  input  logic       clr,
  input  logic       wrap_en,
  output logic [3:0] d,
  output logic       carry,
  output logic       borrow
);

  logic [3:0] d_q;
  logic [3:0] d_d;

  // Ripple out: only when this digit is asked to move past its limit.
  assign carry  = inc && (d_q >= BCD_MAX_DIGIT);
  assign borrow = dec && (d_q == 4'd0);
  assign d      = d_q;

  // Next digit value; wrap_en low means the whole counter is pinned at a limit.
  always_comb begin
    d_d = d_q;
    if (clr) begin
      d_d = 4'd0;
    end else if (load) begin
      d_d = bcd_clamp(load_d);
    end else if (inc) begin
      if (d_q >= BCD_MAX_DIGIT) d_d = wrap_en ? 4'd0 : BCD_MAX_DIGIT;
      else                      d_d = d_q + 4'd1;
    end else if (dec) begin
      if (d_q == 4'd0) d_d = wrap_en ? BCD_MAX_DIGIT : 4'd0;
      else             d_d = d_q - 4'd1;
    end
  end

  // Digit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 4'd0;
    else     d_q <= d_d;
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// N-digit BCD up/down counter with internal prescaler, load/clear,
// wrap or saturate at the limits, and an overflow/underflow pulse.
module bcd_updown_counter
  import bcd_updown_counter_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int TICK_DIV   = 50000000,
  parameter int WRAP       = 1
) (
  input  logic                    clk_50M,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up,
  input  logic                    step,
  input  logic                    clr,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    tick,
  output logic                    ovf,
  output logic                    zero
);

  localparam int              PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic            SATURATE   = (WRAP == 0);

  logic [PW-1:0]       presc_q;
  logic [PW-1:0]       presc_d;
  logic                tick_q;
  logic                ovf_q;
  logic                ovf_d;
  logic                presc_term;
  logic                step_evt;
  logic                do_load;
  logic                do_step;
  logic                wrap_en;
  logic [NUM_DIGITS:0] inc_c;
  logic [NUM_DIGITS:0] dec_c;

  assign presc_term = en && (presc_q == PRESC_LAST);

  // A manual step landing on a terminal count merges into a single event.
  assign step_evt = presc_term | step;
  assign do_load  = load & ~clr;
  assign do_step  = step_evt & ~clr & ~load;

  assign inc_c[0] = do_step & up;
  assign dec_c[0] = do_step & ~up;

  // A ripple out of the top digit is exactly the MAX->0 or 0->MAX event.
  assign ovf_d   = inc_c[NUM_DIGITS] | dec_c[NUM_DIGITS];
  assign wrap_en = ~(SATURATE & ovf_d);

  // Prescaler next value: clear/load restart the tick period.
  always_comb begin
    presc_d = presc_q;
    if (clr || load) begin
      presc_d = '0;
    end else if (en) begin
      presc_d = presc_term ? '0 : presc_q + PW'(1);
    end
  end

  // Prescaler and the one-cycle tick/ovf pulse registers.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= presc_term;
      ovf_q   <= ovf_d;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk     (clk_50M),
      .rst     (rst),
      .inc     (inc_c[g]),
      .dec     (dec_c[g]),
      .load    (do_load),
      .load_d  (load_val[4*g +: 4]),
      .clr     (clr),
      .wrap_en (wrap_en),
      .d       (digits[4*g +: 4]),
      .carry   (inc_c[g+1]),
      .borrow  (dec_c[g+1])
    );
  end

  assign tick = tick_q;
  assign ovf  = ovf_q;
  assign zero = (digits == '0);

endmodule

// File: tb/tb_bcd_updown_counter.sv
module tb_bcd_updown_counter;

  localparam int ND   = 3;
  localparam int TD   = 4;
  localparam int MAXV = 999;

  logic          clk = 1'b0;
  logic          rst, en, up, step, clr, load;
  logic [4*ND-1:0] load_val;
  logic [4*ND-1:0] digits_w, digits_s;
  logic          tick_w, ovf_w, zero_w;
  logic          tick_s, ovf_s, zero_s;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bcd_updown_counter #(.NUM_DIGITS(ND), .TICK_DIV(TD), .WRAP(1)) u_wrap (
    .clk_50M(clk), .rst(rst), .en(en), .up(up), .step(step), .clr(clr),
    .load(load), .load_val(load_val), .digits(digits_w), .tick(tick_w),
    .ovf(ovf_w), .zero(zero_w));

  bcd_updown_counter #(.NUM_DIGITS(ND), .TICK_DIV(TD), .WRAP(0)) u_sat (
    .clk_50M(clk), .rst(rst), .en(en), .up(up), .step(step), .clr(clr),
    .load(load), .load_val(load_val), .digits(digits_s), .tick(tick_s),
    .ovf(ovf_s), .zero(zero_s));

  // Model: plain integer count per instance (0 = wrapping, 1 = saturating).
  int m_cnt [2];
  int m_ovf [2];
  int m_presc;
  int m_tick;

  function automatic int clamp_val(input logic [4*ND-1:0] v);
    int acc = 0;
    int w = 1;
    for (int i = 0; i < ND; i++) begin
      int nib = int'(v[4*i +: 4]);
      if (nib > 9) nib = 9;
      acc += nib * w;
      w *= 10;
    end
    return acc;
  endfunction

  function automatic logic [4*ND-1:0] to_bcd(input int n);
    logic [4*ND-1:0] r = '0;
    int x = n;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_presc = 0;
      m_tick  = 0;
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] = 0;
        m_ovf[k] = 0;
      end
    end else begin
      bit term, evt;
      term   = en && (m_presc == TD - 1);
      m_tick = term ? 1 : 0;
      if (en) m_presc = term ? 0 : m_presc + 1;
      evt = term || step;
      for (int k = 0; k < 2; k++) begin
        m_ovf[k] = 0;
        if (clr) m_cnt[k] = 0;
        else if (load) m_cnt[k] = clamp_val(load_val);
        else if (evt) begin
          if (up) begin
            if (m_cnt[k] == MAXV) begin
              m_ovf[k] = 1;
              m_cnt[k] = (k == 0) ? 0 : MAXV;
            end else m_cnt[k] = m_cnt[k] + 1;
          end else begin
            if (m_cnt[k] == 0) begin
              m_ovf[k] = 1;
              m_cnt[k] = (k == 0) ? MAXV : 0;
            end else m_cnt[k] = m_cnt[k] - 1;
          end
        end
      end
      if (clr || load) m_presc = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("w.digits", 32'(digits_w), 32'(to_bcd(m_cnt[0])));
      chk("w.ovf",    32'(ovf_w),    32'(m_ovf[0]));
      chk("w.tick",   32'(tick_w),   32'(m_tick));
      chk("w.zero",   32'(zero_w),   32'(m_cnt[0] == 0));
      chk("s.digits", 32'(digits_s), 32'(to_bcd(m_cnt[1])));
      chk("s.ovf",    32'(ovf_s),    32'(m_ovf[1]));
      chk("s.tick",   32'(tick_s),   32'(m_tick));
      chk("s.zero",   32'(zero_s),   32'(m_cnt[1] == 0));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; step = 1'b0;
    clr = 1'b0; load = 1'b0; load_val = '0;
    #3;
    chk("rst.digits", 32'(digits_w), 32'h000);
    chk("rst.zero",   32'(zero_w),   32'd1);
    chk("rst.tick",   32'(tick_w),   32'd0);
    chk("rst.ovf",    32'(ovf_w),    32'd0);
    cyc(2);

    // Auto-count
    rst = 1'b0; en = 1'b1; up = 1'b1;
    cyc(3);
    chk("auto.pre.zero", 32'(zero_w), 32'd1);
    cyc(1);
    chk("auto.first",    32'(digits_w), 32'h001);
    chk("auto.tick",     32'(tick_w),   32'd1);
    chk("auto.zero",     32'(zero_w),   32'd0);
    cyc(8);
    chk("auto.third",    32'(digits_w), 32'h003);

    // Wrap / saturate at MAX
    en = 1'b0; load = 1'b1; load_val = 12'h998;
    cyc(1);
    load = 1'b0;
    chk("load998", 32'(digits_w), 32'h998);
    step = 1'b1;
    cyc(1);
    chk("up999",   32'(digits_w), 32'h999);
    chk("up999.ovf", 32'(ovf_w), 32'd0);
    cyc(1);
    chk("wrap.up",     32'(digits_w), 32'h000);
    chk("wrap.up.ovf", 32'(ovf_w),    32'd1);
    chk("sat.up",      32'(digits_s), 32'h999);
    chk("sat.up.ovf",  32'(ovf_s),    32'd1);
    step = 1'b0;
    cyc(1);
    chk("ovf.oneshot", 32'(ovf_w), 32'd0);
    up = 1'b0; step = 1'b1;
    cyc(1);
    chk("wrap.dn",     32'(digits_w), 32'h999);
    chk("wrap.dn.ovf", 32'(ovf_w),    32'd1);
    step = 1'b0;

    // Saturate at 0
    load = 1'b1; load_val = 12'h000;
    cyc(1);
    load = 1'b0; step = 1'b1;
    cyc(1);
    chk("sat.dn",     32'(digits_s), 32'h000);
    chk("sat.dn.ovf", 32'(ovf_s),    32'd1);
    chk("wrap.dn0",   32'(digits_w), 32'h999);
    step = 1'b0; up = 1'b1;

    // Priority and event merge
    en = 1'b1; clr = 1'b1; load = 1'b1; step = 1'b1; load_val = 12'h555;
    cyc(1);
    chk("prio.clr", 32'(digits_w), 32'h000);
    clr = 1'b0; load_val = 12'h123;
    cyc(1);
    chk("prio.load", 32'(digits_w), 32'h123);
    load = 1'b0; step = 1'b0;
    cyc(3);
    chk("merge.pre", 32'(digits_w), 32'h123);
    step = 1'b1;
    cyc(1);
    chk("merge.once", 32'(digits_w), 32'h124);
    chk("merge.tick", 32'(tick_w),   32'd1);
    step = 1'b0; en = 1'b0;

    // Load clamp and carry ripple
    load = 1'b1; load_val = 12'hA5F;
    cyc(1);
    chk("clamp", 32'(digits_w), 32'h959);
    load = 1'b0; step = 1'b1;
    cyc(1);
    chk("carry1", 32'(digits_w), 32'h960);
    step = 1'b0; load = 1'b1; load_val = 12'h099;
    cyc(1);
    load = 1'b0; step = 1'b1;
    cyc(1);
    chk("carry2", 32'(digits_w), 32'h100);
    step = 1'b0;

    // Async reset mid-count discards a pending step
    load = 1'b1; load_val = 12'h057;
    cyc(1);
    load = 1'b0;
    chk("load057", 32'(digits_w), 32'h057);
    step = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("async.digits", 32'(digits_w), 32'h000);
    chk("async.zero",   32'(zero_w),   32'd1);
    cyc(1);
    rst = 1'b0; step = 1'b0; en = 1'b0;
    cyc(5);
    chk("frozen", 32'(digits_w), 32'h000);
    chk("frozen.tick", 32'(tick_w), 32'd0);
    step = 1'b1;
    cyc(1);
    chk("manual.en0", 32'(digits_w), 32'h001);
    step = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
